// File: rtl/mul_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_unit_pkg
//  Description : Shared constants for the iterative RV32M multiplier:
//                sequencer state encodings and op_sel codes. The op_sel codes
//                match funct3[1:0] and are reused by the instruction decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_unit_pkg;

    // Width of the shift-add step counter (32 steps).
    localparam int CNT_W = 5;

    // op_sel codes, funct3[1:0] of the RV32M multiply group.
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    // Sequencer states. Every operation walks the full chain, so latency is fixed.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_NEG_A  = 3'd1,
        S_NEG_B  = 3'd2,
        S_MUL    = 3'd3,
        S_NEG_LO = 3'd4,
        S_NEG_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

endpackage : mul_unit_pkg
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================================
//  Module      : adder
//  Description : 32-bit adder built from eight 4-bit carry-lookahead groups
//                with the group carries rippled between them.
//  Ports       : a, b    - operands (32 bit)
//                cin     - carry in
//                sum     - a + b + cin (32 bit)
//                cout    - carry out of bit 31
//                v_flag  - signed overflow (carry into bit 31 ^ carry out)
//  Revision    : 1.0 - initial release
// ============================================================================
module adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        v_flag
);

    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [32:0] w_c;

    assign w_g    = a & b;
    assign w_p    = a ^ b;
    assign w_c[0] = cin;

    generate
        for (genvar k = 0; k < 8; k++) begin : g_grp
            localparam int B = 4 * k;
            // Carries inside a group are fully looked ahead from the group carry-in.
            assign w_c[B+1] = w_g[B]
                            | (w_p[B] & w_c[B]);
            assign w_c[B+2] = w_g[B+1]
                            | (w_p[B+1] & w_g[B])
                            | (w_p[B+1] & w_p[B] & w_c[B]);
            assign w_c[B+3] = w_g[B+2]
                            | (w_p[B+2] & w_g[B+1])
                            | (w_p[B+2] & w_p[B+1] & w_g[B])
                            | (w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
            assign w_c[B+4] = w_g[B+3]
                            | (w_p[B+3] & w_g[B+2])
                            | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                            | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B])
                            | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_p[B] & w_c[B]);
        end
    endgenerate

    assign sum    = w_p ^ w_c[31:0];
    assign cout   = w_c[32];
    assign v_flag = w_c[31] ^ w_c[32];

endmodule : adder
`default_nettype wire

// File: rtl/mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mul_unit
//  Description : Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU). Operands
//                are made unsigned, multiplied by 32 shift-add steps and the
//                64-bit product is negated back when the signs differ. One
//                shared adder does every arithmetic pass. Fixed latency of
//                37 cycles from accepted start to done.
//  Ports       : clk, reset (sync, active high)
//                start  - launch, sampled only in IDLE
//                flush  - abort in-flight operation
//                op_sel - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//                rs1    - multiplicand, rs2 - multiplier
//                busy   - operation in flight (cycles 1..36)
//                done   - one-cycle result-valid pulse
//                result - low word (MUL) or high word, held until next done
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op_sel,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    import mul_unit_pkg::*;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_q;      // multiplicand (magnitude after NEG_A)
    logic [XLEN-1:0]   b_q;      // multiplier, becomes product low word
    logic [XLEN-1:0]   hi_q;     // product high word
    logic [CNT_W-1:0]  cnt_q;
    logic              sa_q;
    logic              sb_q;
    logic              neg_q;
    logic              nc_q;     // carry from low-word negation into high word
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   w_add_a;
    logic [XLEN-1:0]   w_add_b;
    logic              w_add_cin;
    logic [XLEN-1:0]   w_sum;
    logic              w_cout;
    logic              w_unused_v_flag;

    logic              w_sa;
    logic              w_sb;

    assign w_sa = ((op_sel == OP_MULH) || (op_sel == OP_MULHSU)) ? rs1[XLEN-1] : 1'b0;
    assign w_sb = (op_sel == OP_MULH) ? rs2[XLEN-1] : 1'b0;

    // Adder operand select. Negation is ~x + 1 (or + nc for the high word).
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (state_q)
            S_NEG_A: begin
                w_add_a   = ~a_q;
                w_add_cin = 1'b1;
            end
            S_NEG_B: begin
                w_add_a   = ~b_q;
                w_add_cin = 1'b1;
            end
            S_MUL: begin
                w_add_a = hi_q;
                w_add_b = b_q[0] ? a_q : '0;
            end
            S_NEG_LO: begin
                w_add_a   = ~b_q;
                w_add_cin = 1'b1;
            end
            S_NEG_HI: begin
                w_add_a   = ~hi_q;
                w_add_cin = nc_q;
            end
            default: ;
        endcase
    end

    adder u_adder (
        .a      (w_add_a),
        .b      (w_add_b),
        .cin    (w_add_cin),
        .sum    (w_sum),
        .cout   (w_cout),
        .v_flag (w_unused_v_flag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            cnt_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            neg_q    <= 1'b0;
            nc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                // Abort: result keeps its old value, no done pulse.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            op_q    <= op_sel;
                            a_q     <= rs1;
                            b_q     <= rs2;
                            hi_q    <= '0;
                            cnt_q   <= '0;
                            sa_q    <= w_sa;
                            sb_q    <= w_sb;
                            neg_q   <= w_sa ^ w_sb;
                            nc_q    <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_NEG_A;
                        end
                    end
                    S_NEG_A: begin
                        if (sa_q) begin
                            a_q <= w_sum;
                        end
                        state_q <= S_NEG_B;
                    end
                    S_NEG_B: begin
                        if (sb_q) begin
                            b_q <= w_sum;
                        end
                        cnt_q   <= '0;
                        state_q <= S_MUL;
                    end
                    S_MUL: begin
                        // {HI, B} <= {carry, sum, B} >> 1
                        hi_q <= {w_cout, w_sum[XLEN-1:1]};
                        b_q  <= {w_sum[0], b_q[XLEN-1:1]};
                        if (cnt_q == CNT_W'(XLEN - 1)) begin
                            state_q <= S_NEG_LO;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_NEG_LO: begin
                        if (neg_q) begin
                            b_q  <= w_sum;
                            nc_q <= w_cout;
                        end
                        state_q <= S_NEG_HI;
                    end
                    S_NEG_HI: begin
                        // Result is registered on the way into DONE so it is
                        // valid together with the done pulse.
                        if (neg_q) begin
                            hi_q <= w_sum;
                        end
                        if (op_q == OP_MUL) begin
                            result_q <= b_q;
                        end else begin
                            result_q <= neg_q ? w_sum : hi_q;
                        end
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule : mul_unit
`default_nettype wire

// File: tb/tb_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_unit
//  Description : Self-checking bench for mul_unit: table of directed vectors
//                plus hand-written sequences for start-while-busy, start in
//                DONE, flush and mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [1:0]  op_sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    mul_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .op_sel (op_sel),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of cycle 38.
    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        int cyc;
        int bad;
        start  = 1'b1;
        op_sel = op;
        rs1    = a;
        rs2    = b;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        bad   = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) bad++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'd37);
        chk({tag, " busy_window"}, 32'(bad), 32'd0);
        chk({tag, " result"}, result, exp);
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int dcount;
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{2'b00, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[4]  = '{2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF};
        vecs[5]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[6]  = '{2'b01, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
        vecs[8]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[9]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
        vecs[10] = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
        vecs[11] = '{2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
        vecs[12] = '{2'b10, 32'h0000_0003, 32'hFFFF_FFFE, 32'h0000_0002};
        vecs[13] = '{2'b01, 32'h0000_0003, 32'hFFFF_FFFE, 32'hFFFF_FFFF};

        reset  = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        op_sel = 2'b00;
        rs1    = '0;
        rs2    = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Start while busy is ignored; start during DONE is ignored; start in IDLE accepted.
        start = 1'b1; op_sel = 2'b00; rs1 = 32'd7; rs2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        repeat (9) begin @(negedge clk); cyc++; end
        start = 1'b1; op_sel = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
        @(negedge clk); cyc++;
        start = 1'b0;
        while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("busy_start latency", 32'(cyc), 32'd37);
        chk("busy_start result", result, 32'h0000_002A);
        start = 1'b1; op_sel = 2'b00; rs1 = 32'd3; rs2 = 32'd5;
        @(negedge clk);
        chk("done_start ignored busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("idle_start accepted busy", {31'd0, busy}, 32'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        chk("idle_start latency", 32'(cyc), 32'd37);
        chk("idle_start result", result, 32'h0000_000F);
        @(negedge clk);

        // Flush at cycle 20: back to IDLE, no done, result unchanged.
        start = 1'b1; op_sel = 2'b11; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush result", result, 32'h0000_000F);
        dcount = 0;
        repeat (40) begin
            if (done === 1'b1) dcount++;
            @(negedge clk);
        end
        chk("flush no_done", 32'(dcount), 32'd0);

        // Flush together with start in IDLE drops the start.
        flush = 1'b1; start = 1'b1;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        chk("flush_start busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Reset at cycle 15 clears outputs, then a fresh MUL works.
        start = 1'b1; op_sel = 2'b00; rs1 = 32'd7; rs2 = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        chk("midreset result", result, 32'd0);
        do_op("after_reset", 2'b00, 32'd3, 32'd5, 32'h0000_000F);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mul_unit
`default_nettype wire
